// File: rtl/vga.sv
// vga: 640x480 video timing with a 160x120 1-bit frame buffer, each pixel
// drawn as a 4x4 block. Written over an 8-bit register bus:
// 0xB0 = X, 0xB1 = Y, 0xB2 = write BUS_DATA[0] at (X,Y).
// Build option: define VGA_COLOUR_REG_EN to make the background (0xB3) and
// foreground (0xB4) colours writable; otherwise they are fixed at 0x00 / 0xFF.
// The vertical geometry is parameterised (defaults give the 525-line frame).
`timescale 1ns/1ps
module vga #(
  parameter int V_TOTAL     = 525,
  parameter int V_SYNC      = 2,
  parameter int V_ACT_START = 35,
  parameter int V_ACT_END   = 515
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic [7:0] BUS_ADDR,
  input  logic [7:0] BUS_DATA,
  input  logic       BUS_WE,
  output logic       HS,
  output logic       VS,
  output logic [7:0] COLOUR_OUT
);

  localparam logic [9:0] H_LAST      = 10'd799;
  localparam logic [9:0] H_SYNC      = 10'd96;
  localparam logic [9:0] H_ACT_START = 10'd144;
  localparam logic [9:0] H_ACT_END   = 10'd784;
  localparam logic [9:0] V_LAST      = 10'(V_TOTAL - 1);
  localparam logic [9:0] V_SYNC_W    = 10'(V_SYNC);
  localparam logic [9:0] V_START_W   = 10'(V_ACT_START);
  localparam logic [9:0] V_END_W     = 10'(V_ACT_END);

  localparam logic [7:0] ADDR_X   = 8'hB0;
  localparam logic [7:0] ADDR_Y   = 8'hB1;
  localparam logic [7:0] ADDR_PIX = 8'hB2;

  logic [1:0]  div_q, div_d;
  logic [9:0]  hcount_q, hcount_d;
  logic [9:0]  vcount_q, vcount_d;
  logic [7:0]  x_q, x_d;
  logic [7:0]  y_q, y_d;
  logic        hs1_q, hs1_d, vs1_q, vs1_d, act1_q, act1_d;
  logic        hs_q, hs_d, vs_q, vs_d;
  logic [7:0]  colour_q, colour_d;
  logic [7:0]  bg_col, fg_col;
  logic        pix_q;
  logic        tick;
  logic        fb_we;
  logic [14:0] fb_waddr, fb_raddr;
  logic [7:0]  blk_x;
  logic [6:0]  blk_y;

  // Pixel-tick divider and horizontal/vertical raster counters
  always_comb begin
    tick     = (div_q == 2'd3);
    div_d    = div_q + 2'd1;
    hcount_d = hcount_q;
    vcount_d = vcount_q;
    if (tick) begin
      if (hcount_q == H_LAST) begin
        hcount_d = '0;
        vcount_d = (vcount_q == V_LAST) ? '0 : vcount_q + 10'd1;
      end else begin
        hcount_d = hcount_q + 10'd1;
      end
    end
  end

  // Bus register decode; pixel writes use X/Y as held before this edge
  always_comb begin
    x_d = x_q;
    y_d = y_q;
    if (BUS_WE && (BUS_ADDR == ADDR_X)) x_d = BUS_DATA;
    if (BUS_WE && (BUS_ADDR == ADDR_Y)) y_d = BUS_DATA;
    fb_we    = RESET && BUS_WE && (BUS_ADDR == ADDR_PIX) &&
               (x_q < 8'd160) && (y_q < 8'd120);
    fb_waddr = {y_q[6:0], x_q};
  end

`ifdef VGA_COLOUR_REG_EN
  logic [7:0] bg_q, bg_d, fg_q, fg_d;

  // Writable background/foreground colour registers
  always_comb begin
    bg_d = bg_q;
    fg_d = fg_q;
    if (BUS_WE && (BUS_ADDR == 8'hB3)) bg_d = BUS_DATA;
    if (BUS_WE && (BUS_ADDR == 8'hB4)) fg_d = BUS_DATA;
    bg_col = bg_q;
    fg_col = fg_q;
  end

  // Colour register state
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      bg_q <= 8'h00;
      fg_q <= 8'hFF;
    end else begin
      bg_q <= bg_d;
      fg_q <= fg_d;
    end
  end
`else
  // Fixed colours
  always_comb begin
    bg_col = 8'h00;
    fg_col = 8'hFF;
  end
`endif

  // Stage 1 decode (sync, display window, frame-buffer address); stage 2 colour
  always_comb begin
    blk_x    = 8'((hcount_q - H_ACT_START) >> 2);
    blk_y    = 7'((vcount_q - V_START_W) >> 2);
    fb_raddr = {blk_y, blk_x};
    hs1_d    = (hcount_q >= H_SYNC);
    vs1_d    = (vcount_q >= V_SYNC_W);
    act1_d   = (hcount_q >= H_ACT_START) && (hcount_q < H_ACT_END) &&
               (vcount_q >= V_START_W) && (vcount_q < V_END_W);
    hs_d     = hs1_q;
    vs_d     = vs1_q;
    colour_d = act1_q ? (pix_q ? fg_col : bg_col) : 8'h00;
  end

  // Frame buffer: bus write port; contents survive reset
  logic fb_mem [0:32767];
  always_ff @(posedge CLK) begin
    if (fb_we) fb_mem[fb_waddr] <= BUS_DATA[0];
  end

  // Frame buffer registered read port, aligned with stage 1
  always_ff @(posedge CLK) begin
    pix_q <= fb_mem[fb_raddr];
  end

  // Timing, bus and video pipeline state
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      div_q    <= '0;
      hcount_q <= '0;
      vcount_q <= '0;
      x_q      <= '0;
      y_q      <= '0;
      hs1_q    <= 1'b1;
      vs1_q    <= 1'b1;
      act1_q   <= 1'b0;
      hs_q     <= 1'b1;
      vs_q     <= 1'b1;
      colour_q <= 8'h00;
    end else begin
      div_q    <= div_d;
      hcount_q <= hcount_d;
      vcount_q <= vcount_d;
      x_q      <= x_d;
      y_q      <= y_d;
      hs1_q    <= hs1_d;
      vs1_q    <= vs1_d;
      act1_q   <= act1_d;
      hs_q     <= hs_d;
      vs_q     <= vs_d;
      colour_q <= colour_d;
    end
  end

  assign HS         = hs_q;
  assign VS         = vs_q;
  assign COLOUR_OUT = colour_q;

endmodule

// File: tb/tb_vga.sv
// tb_vga: random bus traffic against a cycle-count based reference of the
// raster, with a shortened vertical frame so a whole frame fits in the run.
`timescale 1ns/1ps
module tb_vga;
  localparam int unsigned VT  = 20;
  localparam int unsigned VSY = 2;
  localparam int unsigned VAS = 3;
  localparam int unsigned VAE = 19;

  logic       CLK = 1'b0;
  logic       RESET = 1'b0;
  logic [7:0] BUS_ADDR = 8'h00;
  logic [7:0] BUS_DATA = 8'h00;
  logic       BUS_WE = 1'b0;
  logic       HS, VS;
  logic [7:0] COLOUR_OUT;

  vga #(.V_TOTAL(VT), .V_SYNC(VSY), .V_ACT_START(VAS), .V_ACT_END(VAE)) dut (
    .CLK(CLK), .RESET(RESET), .BUS_ADDR(BUS_ADDR), .BUS_DATA(BUS_DATA),
    .BUS_WE(BUS_WE), .HS(HS), .VS(VS), .COLOUR_OUT(COLOUR_OUT)
  );

  always #5 CLK = ~CLK;

  int          checks = 0;
  int          errors = 0;
  int unsigned cyc = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  bit          model_on = 0;
  bit          mfb [32768];
  logic [7:0]  mx = 0, my = 0, mbg = 8'h00, mfg = 8'hFF;
  bit          rd_last = 0;
  int unsigned kcnt = 0;
  logic [9:0]  exp_video = 10'h300;

  // Expected {HS,VS,COLOUR} for pixel index p (pixels since reset release)
  function automatic logic [9:0] video_at(int unsigned p, bit pix, logic [7:0] bg, logic [7:0] fg);
    int unsigned h, v;
    logic hs, vs;
    logic [7:0] c;
    h = p % 800;
    v = (p / 800) % VT;
    hs = (h >= 96);
    vs = (v >= VSY);
    c = 8'h00;
    if (h >= 144 && h < 784 && v >= VAS && v < VAE) c = pix ? fg : bg;
    return {hs, vs, c};
  endfunction

  // Frame-buffer bit shown at pixel index p: each stored bit covers 4x4 screen pixels
  function automatic int unsigned rd_addr(int unsigned p);
    int unsigned h, v;
    h = p % 800;
    v = (p / 800) % VT;
    if (h >= 144 && h < 784 && v >= VAS && v < VAE)
      return ((v - VAS) / 4) * 256 + (h - 144) / 4;
    return 0;
  endfunction

  // Outputs after edge k show the raster position reached at edge k-2
  initial forever begin
    @(posedge CLK);
    cyc++;
    if (!RESET) begin
      kcnt = 0; mx = 0; my = 0; mbg = 8'h00; mfg = 8'hFF;
      exp_video = 10'h300;
      model_on = 1;
    end else begin
      kcnt++;
      if (kcnt >= 2) exp_video = video_at((kcnt - 2) / 4, rd_last, mbg, mfg);
      else           exp_video = 10'h300;
      rd_last = mfb[rd_addr((kcnt - 1) / 4)];
      if (BUS_WE) begin
        case (BUS_ADDR)
          8'hB0: mx = BUS_DATA;
          8'hB1: my = BUS_DATA;
          8'hB2: if (mx < 160 && my < 120) mfb[int'(my) * 256 + int'(mx)] = BUS_DATA[0];
`ifdef VGA_COLOUR_REG_EN
          8'hB3: mbg = BUS_DATA;
          8'hB4: mfg = BUS_DATA;
`endif
          default: ;
        endcase
      end
    end
  end

  // Every cycle: compare sync and colour against the model
  initial forever begin
    @(negedge CLK);
    if (model_on) chk("video", {22'd0, HS, VS, COLOUR_OUT}, {22'd0, exp_video});
  end

  // ---------------- sync period measurement ----------------
  bit          rst_released = 0;
  bit          meas_done = 0;
  int unsigned hs_f0 = 0, hs_f1 = 0, hs_r0 = 0, vs_f0 = 0, vs_f1 = 0, vs_r0 = 0;

  initial begin
    logic hs_prev, vs_prev;
    int   hs_nf, vs_nf;
    hs_prev = 1'b1; vs_prev = 1'b1; hs_nf = 0; vs_nf = 0;
    wait (rst_released);
    while (!meas_done) begin
      @(negedge CLK);
      if (hs_prev && !HS) begin
        if (hs_nf == 0) hs_f0 = cyc; else if (hs_nf == 1) hs_f1 = cyc;
        hs_nf++;
      end
      if (!hs_prev && HS && hs_nf == 1) hs_r0 = cyc;
      if (vs_prev && !VS) begin
        if (vs_nf == 0) vs_f0 = cyc; else if (vs_nf == 1) vs_f1 = cyc;
        vs_nf++;
      end
      if (!vs_prev && VS && vs_nf == 1) vs_r0 = cyc;
      hs_prev = HS;
      vs_prev = VS;
      if (vs_nf >= 2 && hs_nf >= 2) meas_done = 1;
    end
  end

  // ---------------- bus stimulus ----------------
  task automatic drive(input logic [7:0] a, input logic [7:0] d);
    BUS_ADDR = a; BUS_DATA = d; BUS_WE = 1'b1;
    @(negedge CLK);
  endtask

  task automatic bus_wr(input logic [7:0] a, input logic [7:0] d);
    $display("cycle %0d write addr 0x%02h data 0x%02h reset_n %0b", cyc, a, d, RESET);
    drive(a, d);
  endtask

  task automatic bus_idle(input int n);
    BUS_WE = 1'b0;
    repeat (n) @(negedge CLK);
  endtask

  task automatic rand_writes(input int n);
    for (int i = 0; i < n; i++) begin
      int unsigned r;
      r = $urandom_range(0, 11);
      if (r < 3)       bus_wr(8'hB0, 8'($urandom_range(0, 170)));
      else if (r < 5)  bus_wr(8'hB1, 8'($urandom_range(0, 4)));
      else if (r == 5) bus_wr(8'hB1, 8'($urandom_range(118, 131)));
      else if (r < 9)  bus_wr(8'hB2, 8'($urandom));
      else if (r == 9) bus_wr(8'hB3 + 8'($urandom_range(0, 1)), 8'($urandom));
      else if (r == 10) bus_wr(8'($urandom), 8'($urandom));
      else bus_idle(1);
    end
    bus_idle(1);
  endtask

  initial begin
    logic [7:0] seq [3];
    seq[0] = 8'hB0; seq[1] = 8'hB1; seq[2] = 8'hB2;

    repeat (4) @(negedge CLK);
    RESET = 1'b1;
    rst_released = 1;

    // Clear the displayed rows of the frame buffer
    for (int y = 0; y < 4; y++) begin
      drive(8'hB1, 8'(y));
      for (int x = 0; x < 160; x++) begin
        drive(8'hB0, 8'(x));
        drive(8'hB2, 8'h00);
      end
    end
    bus_idle(1);
    $display("cycle %0d cleared frame-buffer rows 0..3", cyc);

    // One lit pixel, then two writes that must be dropped (X=160, Y=130)
    bus_wr(8'hB0, 8'd5);   bus_wr(8'hB1, 8'd3); bus_wr(8'hB2, 8'h01);
    bus_idle(2);
    bus_wr(8'hB0, 8'd160); bus_wr(8'hB1, 8'd0); bus_wr(8'hB2, 8'h01);
    bus_wr(8'hB0, 8'd5);   bus_wr(8'hB1, 8'd130); bus_wr(8'hB2, 8'h01);
    bus_idle(2);
    rand_writes(40);

    // Back-to-back bursts during the visible area
    while (cyc < 25000) @(negedge CLK);
    for (int b = 0; b < 3; b++) begin
      logic [7:0] d;
      d = 8'($urandom_range(0, 2));
      for (int j = 0; j < 12; j++) bus_wr(seq[j % 3], d + 8'(j));
      bus_idle(1);
    end
    rand_writes(20);

    // Colour registers (ignored unless the colour option is built in)
    while (cyc < 40000) @(negedge CLK);
    bus_wr(8'hB3, 8'h1C);
    bus_wr(8'hB4, 8'hE0);
    bus_idle(1);

    while (!meas_done && cyc < 70000) @(negedge CLK);
    chk("hs_period", hs_f1 - hs_f0, 3200);
    chk("hs_low",    hs_r0 - hs_f0, 384);
    chk("vs_period", vs_f1 - vs_f0, VT * 3200);
    chk("vs_low",    vs_r0 - vs_f0, 6400);
    chk("meas_done", 32'(meas_done), 1);

    // Mid-frame reset with bus writes that must be ignored while held
    RESET = 1'b0;
    bus_wr(8'hB0, 8'd9);
    bus_wr(8'hB2, 8'h01);
    bus_idle(1);
    RESET = 1'b1;
    bus_wr(8'hB2, 8'h01);
    bus_idle(1);
    rand_writes(15);
    repeat (11000) @(negedge CLK);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
